// File: rtl/pkt_ingress_arbiter.sv
// rtl/pkt_ingress_arbiter.sv - round-robin, packet-locked arbiter onto the parser input
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   req_valid/ready   per-source handshake, N bits
//   req_data          N packed 32-bit source words, source i at [32*i +: 32]
//   parser_data_out   granted source word towards the parser
//   parser_valid_out  granted source valid towards the parser
//   parser_ready_in   parser ready
//   fifo_almost_full  blocks the start of a new packet
//   grant_id          current/last granted source
//   busy              packet in progress
//   pkt_done          one-cycle pulse after the last word of a packet
//   pkt_cnt           completed packet count, wraps
module pkt_ingress_arbiter #(
   parameter int N         = 4,
   parameter int PKT_WORDS = 24,
   parameter int GW        = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req_valid,
   input  logic [N*32-1:0] req_data,
   output logic [N-1:0]    req_ready,
   output logic [31:0]     parser_data_out,
   output logic            parser_valid_out,
   input  logic            parser_ready_in,
   input  logic            fifo_almost_full,
   output logic [GW-1:0]   grant_id,
   output logic            busy,
   output logic            pkt_done,
   output logic [15:0]     pkt_cnt
);

   localparam int CW = $clog2(PKT_WORDS + 1);

   typedef enum logic {IDLE, XFER} state_t;

   state_t          state;
   logic [CW-1:0]   word_cnt;
   logic [GW-1:0]   next_grant;
   logic [GW-1:0]   cand;
   logic            found;
   logic [31:0]     sel_data;
   logic            sel_valid;
   logic            xfer;
   logic            last_word;

   // Round-robin search starting one past the last grant, wrapping modulo N.
   always_comb begin
      next_grant = grant_id;
      found      = 1'b0;
      cand       = '0;
      for (int k = 1; k <= N; k++) begin
         cand = GW'((int'(grant_id) + k) % N);
         if (!found && req_valid[cand]) begin
            next_grant = cand;
            found      = 1'b1;
         end
      end
   end

   // Granted source word/valid mux.
   always_comb begin
      sel_data  = '0;
      sel_valid = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (grant_id == GW'(i)) begin
            sel_data  = req_data[32*i +: 32];
            sel_valid = req_valid[i];
         end
      end
   end

   assign xfer      = (state == XFER) && sel_valid && parser_ready_in;
   assign last_word = (word_cnt == CW'(PKT_WORDS - 1));
   assign busy      = (state == XFER);

   // Pass-through only while a packet is locked; valid never depends on parser ready.
   always_comb begin
      req_ready        = '0;
      parser_valid_out = 1'b0;
      parser_data_out  = '0;
      if (!rst && state == XFER) begin
         parser_data_out     = sel_data;
         parser_valid_out    = sel_valid;
         req_ready[grant_id] = parser_ready_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         grant_id <= GW'(N - 1);
         word_cnt <= '0;
         pkt_done <= 1'b0;
         pkt_cnt  <= '0;
      end else begin
         pkt_done <= 1'b0;
         case (state)
            IDLE: begin
               if (|req_valid && !fifo_almost_full) begin
                  grant_id <= next_grant;
                  state    <= XFER;
               end
            end
            XFER: begin
               // Almost-full and other requesters are ignored until the packet ends.
               if (xfer) begin
                  if (last_word) begin
                     word_cnt <= '0;
                     state    <= IDLE;
                     pkt_done <= 1'b1;
                     pkt_cnt  <= pkt_cnt + 16'd1;
                  end else begin
                     word_cnt <= word_cnt + CW'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pkt_ingress_arbiter.sv
// tb/tb_pkt_ingress_arbiter.sv - self-checking bench for pkt_ingress_arbiter
module tb_pkt_ingress_arbiter;

   localparam int N  = 4;
   localparam int PW = 24;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N*32-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic [31:0]     parser_data_out;
   logic            parser_valid_out;
   logic            parser_ready_in;
   logic            fifo_almost_full;
   logic [1:0]      grant_id;
   logic            busy;
   logic            pkt_done;
   logic [15:0]     pkt_cnt;

   pkt_ingress_arbiter #(.N(N), .PKT_WORDS(PW)) dut (
      .clk              (clk),
      .rst              (rst),
      .req_valid        (req_valid),
      .req_data         (req_data),
      .req_ready        (req_ready),
      .parser_data_out  (parser_data_out),
      .parser_valid_out (parser_valid_out),
      .parser_ready_in  (parser_ready_in),
      .fifo_almost_full (fifo_almost_full),
      .grant_id         (grant_id),
      .busy             (busy),
      .pkt_done         (pkt_done),
      .pkt_cnt          (pkt_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          src;
      logic [31:0] data;
   } exp_t;

   typedef struct {
      logic [3:0] mask;
      logic       af;
      logic       exp_busy;
      logic [1:0] exp_grant;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[8];

   bit src_on[N];
   int src_idx[N];
   int src_pkt[N];
   int src_left[N];
   int stall_src, stall_idx, stall_left;
   int rl_at, rl_left;
   int af_at;
   int cyc, xfers, first_xfer_cyc, last_xfer_cyc, done_cyc, done_cnt;
   int n_pass  = 0;
   int n_total = 0;

   function automatic logic [31:0] word(input int s, input int p, input int i);
      if (s == 0 && p == 0 && i == 0)      return 32'hA1A1A1A1;
      if (s == 0 && p == 0 && i == PW - 1) return 32'hD4F40099;
      return {4'hE, 4'(s), 8'(p), 8'h3C, 8'(i)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic push_pkt(input int s, input int p);
      exp_t e;
      for (int i = 0; i < PW; i++) begin
         e.src  = s;
         e.data = word(s, p, i);
         sb.push_back(e);
      end
   endtask

   task automatic drive();
      for (int s = 0; s < N; s++) begin
         req_valid[s] = src_on[s] &&
                        !(s == stall_src && src_idx[s] == stall_idx && stall_left > 0);
         req_data[32*s +: 32] = word(s, src_pkt[s], src_idx[s]);
      end
      parser_ready_in = !(xfers == rl_at && rl_left > 0);
      if (af_at >= 0 && xfers >= af_at) fifo_almost_full = 1'b1;
   endtask

   task automatic clear_stats();
      xfers = 0; cyc = 0; done_cnt = 0; done_cyc = -1;
      first_xfer_cyc = -1; last_xfer_cyc = -1;
   endtask

   task automatic clear_model();
      for (int s = 0; s < N; s++) begin
         src_on[s] = 1'b0; src_idx[s] = 0; src_pkt[s] = 0; src_left[s] = 0;
      end
      stall_src = 0; stall_idx = 0; stall_left = 0;
      rl_at = -1; rl_left = 0; af_at = -1;
      fifo_almost_full = 1'b0;
      sb.delete();
      clear_stats();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_model();
      drive();
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic start(input int s, input int npkts);
      src_on[s]   = 1'b1;
      src_left[s] = npkts;
      drive();
   endtask

   // Entered and left at posedge+1; samples outputs at the negedge in between.
   task automatic cycle();
      logic [N-1:0] fired;
      bit stalled, rl;
      exp_t e;
      @(negedge clk);
      fired   = req_ready & req_valid;
      stalled = stall_left > 0 && src_on[stall_src] && src_idx[stall_src] == stall_idx;
      rl      = !parser_ready_in;
      if (parser_valid_out && parser_ready_in) begin
         chk("xfer_expected", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("xfer_data", parser_data_out, e.data);
            chk("xfer_src", req_ready, 32'(1 << e.src));
         end
         if (xfers == 0) first_xfer_cyc = cyc;
         last_xfer_cyc = cyc;
         xfers++;
      end
      if (pkt_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (stalled && busy) begin
         chk("stall_valid", parser_valid_out, 0);
         chk("stall_grant", grant_id, stall_src);
      end
      if (rl && busy) chk("bp_ready", req_ready, 0);
      @(posedge clk);
      #1;
      cyc++;
      for (int s = 0; s < N; s++) begin
         if (fired[s]) begin
            src_idx[s]++;
            if (src_idx[s] == PW) begin
               src_idx[s] = 0;
               src_pkt[s]++;
               src_left[s]--;
               if (src_left[s] <= 0) src_on[s] = 1'b0;
            end
         end
      end
      if (stalled) stall_left--;
      if (rl) rl_left--;
      drive();
   endtask

   task automatic run(input int budget);
      int n = 0;
      while ((sb.size() > 0 || busy || pkt_done) && n < budget) begin
         cycle();
         n++;
      end
      chk("run_in_budget", n < budget, 1);
      chk("sb_drained", sb.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // mask, almost_full, expected busy, expected grant (pointer starts at 3)
      vecs[0] = '{4'b0001, 1'b0, 1'b1, 2'd0};
      vecs[1] = '{4'b0010, 1'b0, 1'b1, 2'd1};
      vecs[2] = '{4'b1000, 1'b0, 1'b1, 2'd3};
      vecs[3] = '{4'b1100, 1'b0, 1'b1, 2'd2};
      vecs[4] = '{4'b0110, 1'b0, 1'b1, 2'd1};
      vecs[5] = '{4'b1111, 1'b0, 1'b1, 2'd0};
      vecs[6] = '{4'b0100, 1'b1, 1'b0, 2'd3};
      vecs[7] = '{4'b0000, 1'b0, 1'b0, 2'd3};

      // Reset values with inputs active
      rst = 1'b1;
      clear_model();
      req_valid = '1;
      req_data  = '1;
      parser_ready_in = 1'b1;
      #2;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_valid", parser_valid_out, 0);
      chk("rst_data", parser_data_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", pkt_done, 0);
      chk("rst_cnt", pkt_cnt, 0);
      chk("rst_grant", grant_id, 3);

      // First grant from reset for several request patterns
      for (int i = 0; i < 8; i++) begin
         do_reset();
         for (int s = 0; s < N; s++) begin
            src_on[s]   = vecs[i].mask[s];
            src_left[s] = 1;
         end
         fifo_almost_full = vecs[i].af;
         drive();
         cycle();
         chk($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
         chk($sformatf("vec%0d_grant", i), grant_id, vecs[i].exp_grant);
      end

      // Basic packet from source 0
      do_reset();
      push_pkt(0, 0);
      start(0, 1);
      run(200);
      chk("basic_first_cyc", first_xfer_cyc, 1);
      chk("basic_xfers", xfers, PW);
      chk("basic_done_cnt", done_cnt, 1);
      chk("basic_done_cyc", done_cyc, last_xfer_cyc + 1);
      chk("basic_pkt_cnt", pkt_cnt, 1);
      chk("basic_busy", busy, 0);

      // Fairness: 0,1,3 continuous, two packets each
      do_reset();
      push_pkt(0, 0); push_pkt(1, 0); push_pkt(3, 0);
      push_pkt(0, 1); push_pkt(1, 1); push_pkt(3, 1);
      start(0, 2); start(1, 2); start(3, 2);
      run(1000);
      chk("fair_pkt_cnt", pkt_cnt, 6);
      chk("fair_done_cnt", done_cnt, 6);
      chk("fair_last_cyc", last_xfer_cyc, 6 * (PW + 1) - 1);

      // Parser backpressure after word 5 for 3 cycles
      do_reset();
      push_pkt(2, 0);
      rl_at = 5; rl_left = 3;
      start(2, 1);
      run(200);
      chk("bp_xfers", xfers, PW);
      chk("bp_last_cyc", last_xfer_cyc, PW + 3);
      chk("bp_pkt_cnt", pkt_cnt, 1);

      // Almost-full while idle, then mid-packet
      do_reset();
      push_pkt(2, 0);
      fifo_almost_full = 1'b1;
      start(2, 1);
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("af_hold_busy", busy, 0);
      end
      fifo_almost_full = 1'b0;
      af_at = 8;
      cycle();
      chk("af_grant_busy", busy, 1);
      chk("af_grant_id", grant_id, 2);
      run(200);
      chk("af_mid_xfers", xfers, PW);
      chk("af_mid_pkt_cnt", pkt_cnt, 1);

      // Granted source 1 stalls after word 10 while source 0 waits
      do_reset();
      push_pkt(1, 0);
      push_pkt(0, 0);
      start(1, 1);
      cycle();
      chk("stall_granted", grant_id, 1);
      stall_src = 1; stall_idx = 10; stall_left = 5;
      start(0, 1);
      run(400);
      chk("stall_xfers", xfers, 2 * PW);
      chk("stall_pkt_cnt", pkt_cnt, 2);

      // Async reset mid-packet (pkt_cnt is 2 coming in)
      clear_model();
      push_pkt(3, 0);
      start(3, 1);
      for (int i = 0; i < 100 && xfers < 12; i++) cycle();
      chk("ar_reached_12", xfers, 12);
      #2 rst = 1'b1;
      #1;
      chk("ar_busy", busy, 0);
      chk("ar_valid", parser_valid_out, 0);
      chk("ar_ready", req_ready, 0);
      chk("ar_pkt_cnt", pkt_cnt, 0);
      chk("ar_grant", grant_id, 3);
      @(posedge clk);
      #1;
      clear_model();
      rst = 1'b0;
      push_pkt(0, 0);
      push_pkt(3, 0);
      start(0, 1);
      start(3, 1);
      run(400);
      chk("ar_first_cyc", first_xfer_cyc, 1);
      chk("ar_xfers", xfers, 2 * PW);
      chk("ar_pkt_cnt_after", pkt_cnt, 2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
